axi_lite_regfile_slave: RTL
===========================

// Module: axi_lite_regfile_slave
// PURPOSE
// Parametrised AXI4-Lite register-file slave, successor to the fixed 4-register template slave.
// - NUM_REGS read/write control registers, each with byte-strobe writes.
// - NUM_RO_REGS read-only status registers, driven live by fabric inputs.
// - SLVERR on illegal accesses; AW and W accepted independently, in either order.
// - Per-register write-commit pulses for fabric logic.
// PARAMETERS
// AXI_DATA_WIDTH  32            data width in bits; 32 or 64
// AXI_ADDR_WIDTH  32            address width in bits
// NUM_REGS        8             RW registers, word indices 0..NUM_REGS-1; >=1
// NUM_RO_REGS     2             RO registers, indices NUM_REGS..NUM_REGS+NUM_RO_REGS-1; >=0
// RESET_VAL       '0            reset value of every RW register
// PORTS
// S_AXI_ACLK     in   1                        clock, all logic on rising edge
// S_AXI_ARESETN  in   1                        synchronous reset, active low
// S_AXI_AWADDR   in   AXI_ADDR_WIDTH           write address
// S_AXI_AWPROT   in   3                        ignored
// S_AXI_AWVALID  in   1                        write-address valid
// S_AXI_AWREADY  out  1                        write-address ready
// S_AXI_WDATA    in   AXI_DATA_WIDTH           write data
// S_AXI_WSTRB    in   AXI_DATA_WIDTH/8         byte strobes
// S_AXI_WVALID   in   1                        write-data valid
// S_AXI_WREADY   out  1                        write-data ready
// S_AXI_BRESP    out  2                        write response: 00 OKAY, 10 SLVERR
// S_AXI_BVALID   out  1                        write-response valid
// S_AXI_BREADY   in   1                        write-response ready
// S_AXI_ARADDR   in   AXI_ADDR_WIDTH           read address
// S_AXI_ARPROT   in   3                        ignored
// S_AXI_ARVALID  in   1                        read-address valid
// S_AXI_ARREADY  out  1                        read-address ready
// S_AXI_RDATA    out  AXI_DATA_WIDTH           read data
// S_AXI_RRESP    out  2                        read response: 00 OKAY, 10 SLVERR
// S_AXI_RVALID   out  1                        read-data valid
// S_AXI_RREADY   in   1                        read-data ready
// regs_o         out  NUM_REGS*AXI_DATA_WIDTH  RW register contents; reg k in bits [k*DW +: DW]
// wr_pulse_o     out  NUM_REGS                 bit k high for 1 cycle when reg k is written
// ro_regs_i      in   max(1,NUM_RO_REGS)*AXI_DATA_WIDTH  status values, same packing as regs_o
// BEHAVIOUR
// - Reset (ARESETN=0 at a rising edge):
//   - AWREADY, WREADY, ARREADY, BVALID, RVALID, wr_pulse_o -> 0; BRESP, RRESP, RDATA -> 0.
//   - All RW registers -> RESET_VAL; held AW/W state discarded, including a transaction mid-flight.
//   - Ready signals rise on the first edge after reset is released.
// - Address decode:
//   - idx = addr >> log2(DW/8); low byte-offset bits are ignored.
//   - Total = NUM_REGS + NUM_RO_REGS. idx >= Total (upper bits included) is out of range.
// - Write channel:
//   - Two independent holding slots: aw_held and w_held.
//   - AWREADY = !aw_held & !BVALID. WREADY = !w_held & !BVALID.
//   - A handshake at edge N sets the matching slot.
//   - Commit at the first edge where aw_held & w_held: the write is applied, BVALID is set, and both slots are cleared.
//   - Latency is one cycle from the later of AW/W to BVALID.
//   - BVALID and BRESP hold until BREADY; BVALID clears at the handshake edge.
//   - idx < NUM_REGS: byte b is updated only when WSTRB[b]=1; wr_pulse_o[idx] is high in the cycle after commit; BRESP=OKAY. This applies even when WSTRB=0.
//   - RO index or out-of-range idx: no state change, no pulse, BRESP=SLVERR.
// - Read channel:
//   - ARREADY = !RVALID.
//   - The AR handshake at edge N registers RDATA, RRESP and RVALID=1 at edge N; RVALID is visible the next cycle.
//   - RDATA source: RW register, or ro_regs_i sampled at edge N.
//   - Out-of-range read: RDATA=0, RRESP=SLVERR.
//   - RVALID and RDATA hold until RREADY; at most one read outstanding.
// - Read and write channels are independent. A read and a write commit on the same edge to the same register: RDATA returns the pre-write value.
// - No combinational path from any input to any output.
// TESTING
// 1. Write 0xDEADBEEF,0xBAADF00D,0xFEEDFACE,0x0BADC0DE to addr 0x0,0x4,0x8,0xC with WSTRB=4'hF, then read back -> equal data, all RESP=00, wr_pulse_o bits 0..3 each pulse once.
// 2. Reg0=0xDEADBEEF; write 0x11223344 with WSTRB=4'b0101 -> readback 0xDE22BE44, BRESP=00.
// 3. Present W 3 cycles before AW (addr 0x10, data 0xA5A5A5A5) -> BVALID 1 cycle after the AW handshake; reg4=0xA5A5A5A5.
// 4. ro_regs_i reg8=0xCAFE0001; write 0x0 to 0x20 -> BRESP=10, read 0x20 -> 0xCAFE0001 OKAY; read 0x40 -> RDATA=0, RRESP=10.
// 5. Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID and their data stable, AWREADY/WREADY/ARREADY stay 0.
// 6. Assert reset with only AW held -> after release a new AW+W to 0x4 completes normally; the stale AW has no effect; reg1=RESET_VAL elsewhere.

Source files
------------

// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite register-file slave: NUM_REGS byte-strobed RW registers, NUM_RO_REGS live
// status registers, SLVERR on illegal accesses, and a per-register write-commit pulse.
module axi_lite_regfile_slave #(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS       = 8,
  parameter int unsigned NUM_RO_REGS    = 2,
  parameter logic [AXI_DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                                S_AXI_ACLK,
  input  logic                                S_AXI_ARESETN,
  input  logic [AXI_ADDR_WIDTH-1:0]           S_AXI_AWADDR,
  input  logic [2:0]                          S_AXI_AWPROT,
  input  logic                                S_AXI_AWVALID,
  output logic                                S_AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]           S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]         S_AXI_WSTRB,
  input  logic                                S_AXI_WVALID,
  output logic                                S_AXI_WREADY,
  output logic [1:0]                          S_AXI_BRESP,
  output logic                                S_AXI_BVALID,
  input  logic                                S_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]           S_AXI_ARADDR,
  input  logic [2:0]                          S_AXI_ARPROT,
  input  logic                                S_AXI_ARVALID,
  output logic                                S_AXI_ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]           S_AXI_RDATA,
  output logic [1:0]                          S_AXI_RRESP,
  output logic                                S_AXI_RVALID,
  input  logic                                S_AXI_RREADY,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0]  regs_o,
  output logic [NUM_REGS-1:0]                 wr_pulse_o,
  input  logic [((NUM_RO_REGS > 0) ? NUM_RO_REGS : 1)*AXI_DATA_WIDTH-1:0] ro_regs_i
);

  localparam int unsigned DW       = AXI_DATA_WIDTH;
  localparam int unsigned SW       = DW / 8;
  localparam int unsigned ADDR_LSB = $clog2(SW);
  localparam int unsigned IDX_W    = AXI_ADDR_WIDTH - ADDR_LSB;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic                 aw_held_q, aw_held_d;
  logic                 w_held_q, w_held_d;
  logic                 bvalid_q, bvalid_d;
  logic [1:0]           bresp_q, bresp_d;
  logic                 awready_q, awready_d;
  logic                 wready_q, wready_d;
  logic [IDX_W-1:0]     aw_idx_q, aw_idx_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [SW-1:0]        wstrb_q, wstrb_d;
  logic [NUM_REGS-1:0]  wr_pulse_q, wr_pulse_d;
  logic                 reg_we;

  logic                 rvalid_q, rvalid_d;
  logic                 arready_q, arready_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic [1:0]           rresp_q, rresp_d;
  logic [DW-1:0]        rd_word;
  logic                 rd_err;

  logic [DW-1:0]        regs_q [NUM_REGS];

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic [IDX_W-1:0] ar_idx;

  assign aw_hs  = S_AXI_AWVALID & awready_q;
  assign w_hs   = S_AXI_WVALID & wready_q;
  assign b_hs   = bvalid_q & S_AXI_BREADY;
  assign ar_hs  = S_AXI_ARVALID & arready_q;
  assign r_hs   = rvalid_q & S_AXI_RREADY;
  assign commit = aw_held_q & w_held_q & ~bvalid_q;
  assign ar_idx = S_AXI_ARADDR[AXI_ADDR_WIDTH-1:ADDR_LSB];

  // Write channel: independent AW/W holding slots, commit once both are held.
  always_comb begin : wr_next
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wr_pulse_d = '0;
    reg_we     = 1'b0;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[AXI_ADDR_WIDTH-1:ADDR_LSB];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end
    if (b_hs) bvalid_d = 1'b0;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (aw_idx_q < IDX_W'(NUM_REGS)) begin
        reg_we  = 1'b1;
        bresp_d = RESP_OKAY;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
          wr_pulse_d[k] = (aw_idx_q == IDX_W'(k));
        end
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end
    awready_d = ~aw_held_d & ~bvalid_d;
    wready_d  = ~w_held_d & ~bvalid_d;
  end

  // Read channel: decode on the full index so stray upper address bits are out of range.
  always_comb begin : rd_next
    rd_word = '0;
    rd_err  = 1'b1;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (ar_idx == IDX_W'(k)) begin
        rd_word = regs_q[k];
        rd_err  = 1'b0;
      end
    end
    for (int unsigned k = 0; k < NUM_RO_REGS; k++) begin
      if (ar_idx == IDX_W'(NUM_REGS + k)) begin
        rd_word = ro_regs_i[k*DW +: DW];
        rd_err  = 1'b0;
      end
    end
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (r_hs) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
      rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
    end
    arready_d = ~rvalid_d;
  end

  always_ff @(posedge S_AXI_ACLK) begin : ctrl_q
    if (!S_AXI_ARESETN) begin
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_pulse_q <= '0;
      rvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wr_pulse_q <= wr_pulse_d;
      rvalid_q   <= rvalid_d;
      arready_q  <= arready_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // Register file with per-byte strobes.
  always_ff @(posedge S_AXI_ACLK) begin : regfile_q
    if (!S_AXI_ARESETN) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) regs_q[k] <= RESET_VAL;
    end else if (reg_we) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        if (aw_idx_q == IDX_W'(k)) begin
          for (int unsigned b = 0; b < SW; b++) begin
            if (wstrb_q[b]) regs_q[k][8*b +: 8] <= wdata_q[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin : regs_pack
    regs_o = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) regs_o[k*DW +: DW] = regs_q[k];
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign wr_pulse_o    = wr_pulse_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

endmodule
